// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS core: FETCH/DECODE/EXECUTE/WRITEBACK over a req/ack instruction port.
// Latency: 4 cycles per ALU op (3 for branches/illegal) plus one per fetch wait cycle; one idle cycle after reset release.
// Backpressure: holds imem_req_o with a stable address until imem_ack_i; ack is ignored while req is low.
// Optional feature: define MIPS_MC_BRANCH_EN to evaluate beq/bne; otherwise they retire as legal NOPs.
module mips_multicycle_core #(
    parameter logic [31:0] PC_RESET        = 32'h0040_0000,
    parameter int          IMEM_ADDR_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req_o,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                       imem_ack_i,
    input  logic [31:0]                imem_rdata_i,
    output logic [31:0]                pc_o,
    output logic [31:0]                alu_result_o,
    output logic                       retire_o,
    output logic                       illegal_o
);

    typedef enum logic [1:0] {
        S_FETCH     = 2'd0,
        S_DECODE    = 2'd1,
        S_EXECUTE   = 2'd2,
        S_WRITEBACK = 2'd3
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_req;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_imm;
    logic [31:0] r_alu;
    logic [31:0] r_alu_result;
    logic [31:0] r_rf [0:31];

    logic [5:0]  w_opcode;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_shamt;
    logic [5:0]  w_funct;
    logic [15:0] w_imm16;
    logic [4:0]  w_dest;

    logic        w_legal;
    logic        w_is_branch;
    logic        w_is_rtype;
    logic        w_use_zext;
    logic        w_taken;
    logic [31:0] w_alu;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_target;
    logic        w_fetch_done;
    logic        w_retire;
    logic        w_illegal;

    assign w_opcode = r_ir[31:26];
    assign w_rs     = r_ir[25:21];
    assign w_rt     = r_ir[20:16];
    assign w_rd     = r_ir[15:11];
    assign w_shamt  = r_ir[10:6];
    assign w_funct  = r_ir[5:0];
    assign w_imm16  = r_ir[15:0];
    assign w_dest   = w_is_rtype ? w_rd : w_rt;

    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_br_target  = w_pc_plus4 + {r_imm[29:0], 2'b00};
    // An ack only counts while a request is actually outstanding.
    assign w_fetch_done = r_req && imem_ack_i;

    assign imem_req_o   = r_req;
    assign imem_addr_o  = r_pc[IMEM_ADDR_WIDTH-1:0];
    assign pc_o         = r_pc;
    assign alu_result_o = r_alu_result;
    assign retire_o     = w_retire;
    assign illegal_o    = w_illegal;

    // Instruction decode and ALU; operands are the registered A/B/imm values.
    always_comb begin
        w_legal     = 1'b0;
        w_is_branch = 1'b0;
        w_is_rtype  = 1'b0;
        w_use_zext  = 1'b0;
        w_alu       = 32'd0;
        case (w_opcode)
            OP_RTYPE: begin
                w_is_rtype = 1'b1;
                w_legal    = 1'b1;
                case (w_funct)
                    FN_ADD:  w_alu = r_a + r_b;
                    FN_SUB:  w_alu = r_a - r_b;
                    FN_AND:  w_alu = r_a & r_b;
                    FN_OR:   w_alu = r_a | r_b;
                    FN_NOR:  w_alu = ~(r_a | r_b);
                    FN_SLL:  w_alu = r_b << w_shamt;
                    FN_SRL:  w_alu = r_b >> w_shamt;
                    default: w_legal = 1'b0;
                endcase
            end
            OP_ADDI: begin
                w_legal = 1'b1;
                w_alu   = r_a + r_imm;
            end
            OP_ORI: begin
                w_legal    = 1'b1;
                w_use_zext = 1'b1;
                w_alu      = r_a | r_imm;
            end
            OP_BEQ, OP_BNE: begin
                w_legal     = 1'b1;
                w_is_branch = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Branch resolution; without the branch feature beq/bne always fall through.
    always_comb begin
        w_taken = 1'b0;
`ifdef MIPS_MC_BRANCH_EN
        if (w_opcode == OP_BEQ) begin
            w_taken = (r_a == r_b);
        end else if (w_opcode == OP_BNE) begin
            w_taken = (r_a != r_b);
        end
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic plus the retire/illegal pulses of the final cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_retire    = 1'b0;
        w_illegal   = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (w_fetch_done) begin
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                w_state_nxt = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (!w_legal) begin
                    w_state_nxt = S_FETCH;
                    w_retire    = 1'b1;
                    w_illegal   = 1'b1;
                end else if (w_is_branch) begin
                    w_state_nxt = S_FETCH;
                    w_retire    = 1'b1;
                end else begin
                    w_state_nxt = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                w_state_nxt = S_FETCH;
                w_retire    = 1'b1;
            end
            default: w_state_nxt = S_FETCH;
        endcase
    end

    // Fetch request: high in every FETCH cycle, dropped after the accepting edge.
    // Registered so it is low during reset and for the first cycle after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req <= 1'b0;
        end else begin
            r_req <= (w_state_nxt == S_FETCH);
        end
    end

    // Datapath registers: IR, operands, ALU latch, PC and retired result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ir         <= 32'd0;
            r_a          <= 32'd0;
            r_b          <= 32'd0;
            r_imm        <= 32'd0;
            r_alu        <= 32'd0;
            r_pc         <= PC_RESET;
            r_alu_result <= 32'd0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_fetch_done) begin
                        r_ir <= imem_rdata_i;
                    end
                end
                S_DECODE: begin
                    r_a   <= r_rf[w_rs];
                    r_b   <= r_rf[w_rt];
                    r_imm <= w_use_zext ? {16'd0, w_imm16} : {{16{w_imm16[15]}}, w_imm16};
                end
                S_EXECUTE: begin
                    r_alu <= w_alu;
                    if (!w_legal || w_is_branch) begin
                        r_pc <= w_taken ? w_br_target : w_pc_plus4;
                    end
                end
                S_WRITEBACK: begin
                    r_alu_result <= r_alu;
                    r_pc         <= w_pc_plus4;
                end
                default: ;
            endcase
        end
    end

    // Register file write port; $0 is never written so it always reads 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                r_rf[i] <= 32'd0;
            end
        end else if (r_state == S_WRITEBACK && w_dest != 5'd0) begin
            r_rf[w_dest] <= r_alu;
        end
    end

endmodule
